// File: rtl/mult_seq_pkg.sv
// Shared constants and types for the multi-cycle multiplier sequencer.
package mult_seq_pkg;

  localparam int unsigned OPW   = 32;
  localparam int unsigned EXTW  = 33;
  localparam int unsigned PRODW = 66;

  typedef enum logic [1:0] {
    OpMul    = 2'b00,
    OpMulh   = 2'b01,
    OpMulhsu = 2'b10,
    OpMulhu  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    StIdle,
    StTree,
    StAdd,
    StDone
  } state_e;

endpackage

// File: rtl/mult_final_add.sv
// Carry-propagate add of the registered compressor rows and product-half select.
module mult_final_add
  import mult_seq_pkg::*;
(
  input  logic [PRODW-1:0] sum_i,
  input  logic [PRODW-1:0] carry_i,
  input  op_e              op_i,
  output logic [2*OPW-1:0] prod_o,
  output logic [OPW-1:0]   half_o
);

  logic [PRODW-1:0] p;
  logic             unused_p_hi;

  assign p           = sum_i + carry_i;
  // Bits above 63 are sign-extension residue of the 33x33 tree.
  assign unused_p_hi = ^p[PRODW-1:2*OPW];
  assign prod_o      = p[2*OPW-1:0];
  assign half_o      = (op_i == OpMul) ? p[OPW-1:0] : p[2*OPW-1:OPW];

endmodule

// File: rtl/mult_seq_ctrl.sv
// Sequencer for the 33x33 compressor-tree multiplier with a one-entry product cache.
module mult_seq_ctrl
  import mult_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [1:0]       op_i,
  input  logic [OPW-1:0]   a_i,
  input  logic [OPW-1:0]   b_i,
  output logic             resp_valid_o,
  input  logic             resp_ready_i,
  output logic [OPW-1:0]   result_o,
  output logic             busy_o,
  output logic [EXTW-1:0]  tree_a_o,
  output logic [EXTW-1:0]  tree_b_o,
  input  logic [PRODW-1:0] tree_sum_i,
  input  logic [PRODW-1:0] tree_carry_i
);

  state_e           state_q, state_d;
  op_e              op_q, cop_q, op_in;
  logic [EXTW-1:0]  ta_q, tb_q;
  logic [PRODW-1:0] sum_q, carry_q;
  logic [OPW-1:0]   result_q, ca_q, cb_q;
  logic [2*OPW-1:0] cprod_q, prod;
  logic             cvalid_q;
  logic [OPW-1:0]   add_half, hit_half;
  logic             accept, hit, a_sgn, b_sgn;
  logic             load_tree, load_rows, load_add, load_hit;

  assign op_in       = op_e'(op_i);
  assign req_ready_o = (state_q == StIdle) && !flush_i;
  assign accept      = req_valid_i && req_ready_o;
  assign a_sgn       = (op_in == OpMulh) || (op_in == OpMulhsu);
  assign b_sgn       = (op_in == OpMulh);
  // Low half is signedness-independent, so MUL may reuse any cached op's product.
  assign hit         = cvalid_q && (a_i == ca_q) && (b_i == cb_q) &&
                       ((op_in == OpMul) || (op_in == cop_q));
  assign hit_half    = (op_in == OpMul) ? cprod_q[OPW-1:0] : cprod_q[2*OPW-1:OPW];

  mult_final_add u_final_add (
    .sum_i   (sum_q),
    .carry_i (carry_q),
    .op_i    (op_q),
    .prod_o  (prod),
    .half_o  (add_half)
  );

  always_comb begin
    state_d   = state_q;
    load_tree = 1'b0;
    load_rows = 1'b0;
    load_add  = 1'b0;
    load_hit  = 1'b0;
    case (state_q)
      StIdle: begin
        if (accept) begin
          if (hit) begin
            state_d  = StDone;
            load_hit = 1'b1;
          end else begin
            state_d   = StTree;
            load_tree = 1'b1;
          end
        end
      end
      StTree: begin
        state_d   = StAdd;
        load_rows = 1'b1;
      end
      StAdd: begin
        state_d  = StDone;
        load_add = 1'b1;
      end
      StDone: begin
        if (resp_ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (flush_i) begin
      state_d   = StIdle;
      load_rows = 1'b0;
      load_add  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      op_q     <= OpMul;
      ta_q     <= '0;
      tb_q     <= '0;
      sum_q    <= '0;
      carry_q  <= '0;
      result_q <= '0;
      ca_q     <= '0;
      cb_q     <= '0;
      cop_q    <= OpMul;
      cprod_q  <= '0;
      cvalid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) op_q <= op_in;
      // Tree operands only move on a miss to avoid toggling the tree.
      if (load_tree) begin
        ta_q <= {a_sgn & a_i[OPW-1], a_i};
        tb_q <= {b_sgn & b_i[OPW-1], b_i};
      end
      if (load_rows) begin
        sum_q   <= tree_sum_i;
        carry_q <= tree_carry_i;
      end
      if (load_hit) begin
        result_q <= hit_half;
      end else if (load_add) begin
        result_q <= add_half;
      end
      if (load_add) begin
        ca_q     <= ta_q[OPW-1:0];
        cb_q     <= tb_q[OPW-1:0];
        cop_q    <= op_q;
        cprod_q  <= prod;
        cvalid_q <= 1'b1;
      end
    end
  end

  assign resp_valid_o = (state_q == StDone);
  assign busy_o       = (state_q != StIdle);
  assign result_o     = result_q;
  assign tree_a_o     = ta_q;
  assign tree_b_o     = tb_q;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Directed scoreboard bench for mult_seq_ctrl with an ideal split-row tree model.
module tb_mult_seq_ctrl;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  op_in;
  logic [31:0] a_in, b_in;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] result;
  logic        busy;
  logic [32:0] tree_a, tree_b;
  logic [65:0] tree_sum, tree_carry, tree_prod, split_r;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  mult_seq_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush_i      (flush),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .op_i         (op_in),
    .a_i          (a_in),
    .b_i          (b_in),
    .resp_valid_o (resp_valid),
    .resp_ready_i (resp_ready),
    .result_o     (result),
    .busy_o       (busy),
    .tree_a_o     (tree_a),
    .tree_b_o     (tree_b),
    .tree_sum_i   (tree_sum),
    .tree_carry_i (tree_carry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Ideal tree: exact signed 33x33 product split into two rows by a random offset.
  always_comb begin
    tree_prod  = {{33{tree_a[32]}}, tree_a} * {{33{tree_b[32]}}, tree_b};
    tree_carry = split_r;
    tree_sum   = tree_prod - split_r;
  end

  function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] ea, eb, p;
    ea = {{32{((op == 2'b01) || (op == 2'b10)) & a[31]}}, a};
    eb = {{32{(op == 2'b01) & b[31]}}, b};
    p  = ea * eb;
    return (op == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp)
    else begin
      n_errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit push);
    int w = 0;
    logic [95:0] rnd;
    rnd     = {$urandom, $urandom, $urandom};
    split_r = rnd[65:0];
    while (!req_ready && w < 10) begin
      @(posedge clk); #1;
      w++;
    end
    check("req_ready", {63'd0, req_ready}, 64'd1);
    op_in     = op;
    a_in      = a;
    b_in      = b;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (push) exp_q.push_back(ref_mul(op, a, b));
  endtask

  // Called at accept edge + 1: latency counts cycles until resp_valid is seen.
  task automatic collect(input string tag, input int exp_lat);
    int lat = 1;
    logic [31:0] exp;
    while (!resp_valid && lat < 8) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_valid"}, {63'd0, resp_valid}, 64'd1);
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 64'd0, 64'd1);
    end else begin
      exp = exp_q.pop_front();
      check({tag, "_result"}, {32'd0, result}, {32'd0, exp});
    end
    if (resp_ready) begin
      @(posedge clk); #1;
      check({tag, "_drop"}, {63'd0, resp_valid}, 64'd0);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    flush      = 1'b0;
    req_valid  = 1'b0;
    op_in      = 2'b00;
    a_in       = '0;
    b_in       = '0;
    resp_ready = 1'b1;
    split_r    = '0;
    #12;
    check("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_result", {32'd0, result}, 64'd0);
    check("rst_tree_a", {31'd0, tree_a}, 64'd0);
    check("rst_tree_b", {31'd0, tree_b}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_req_ready", {63'd0, req_ready}, 64'd1);

    // MULHU all-ones.
    issue(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    collect("mulhu_ff", 3);

    // MULH min*min then MUL hit.
    issue(2'b01, 32'h8000_0000, 32'h8000_0000, 1'b1);
    collect("mulh_min", 3);
    issue(2'b00, 32'h8000_0000, 32'h8000_0000, 1'b1);
    collect("mul_hit", 1);
    check("hit_tree_a_hold", {31'd0, tree_a}, 64'h1_8000_0000);

    // MULHSU then MULH with same operands must miss.
    issue(2'b10, 32'hFFFF_FFFF, 32'h0000_0002, 1'b1);
    collect("mulhsu", 3);
    issue(2'b01, 32'hFFFF_FFFF, 32'h0000_0002, 1'b1);
    collect("mulh_miss", 3);

    // Consumer stall in DONE.
    resp_ready = 1'b0;
    issue(2'b00, 32'h0000_1234, 32'h0000_0010, 1'b1);
    collect("stall", 3);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("stall_valid", {63'd0, resp_valid}, 64'd1);
      check("stall_result", {32'd0, result}, 64'h0001_2340);
      check("stall_req_ready", {63'd0, req_ready}, 64'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    check("stall_release", {63'd0, resp_valid}, 64'd0);

    // Flush in IDLE blocks acceptance.
    flush     = 1'b1;
    req_valid = 1'b1;
    op_in     = 2'b00;
    a_in      = 32'd9;
    b_in      = 32'd9;
    #1;
    check("flush_idle_ready", {63'd0, req_ready}, 64'd0);
    @(posedge clk); #1;
    check("flush_idle_busy", {63'd0, busy}, 64'd0);
    req_valid = 1'b0;
    flush     = 1'b0;

    // Flush in ADD: no response, no cache write.
    issue(2'b01, 32'd3, 32'd5, 1'b0);
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_add_busy", {63'd0, busy}, 64'd0);
    for (int i = 0; i < 4; i++) begin
      check("flush_add_valid", {63'd0, resp_valid}, 64'd0);
      @(posedge clk); #1;
    end
    issue(2'b00, 32'd3, 32'd5, 1'b1);
    collect("post_flush_mul", 3);

    // Async reset during TREE invalidates the cache.
    issue(2'b11, 32'hFFFF_FFFF, 32'd7, 1'b1);
    collect("pre_rst", 3);
    issue(2'b10, 32'h0000_1234, 32'h0000_5678, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", {63'd0, resp_valid}, 64'd0);
    check("arst_busy", {63'd0, busy}, 64'd0);
    check("arst_result", {32'd0, result}, 64'd0);
    check("arst_tree_a", {31'd0, tree_a}, 64'd0);
    check("arst_tree_b", {31'd0, tree_b}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    issue(2'b00, 32'hFFFF_FFFF, 32'd7, 1'b1);
    collect("post_rst_miss", 3);

    check("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mult_seq_ctrl.md
# mult_seq_ctrl

Sequencer for the 33x33 compressor-tree multiplier in the modified cv32e40p multiply unit. It accepts MUL/MULH/MULHSU/MULHU requests from the EX stage, sign-extends and drives operands into the combinational tree, and registers the tree's final sum/carry rows. It then performs the final carry-propagate add and returns the selected 32-bit half through a valid/ready handshake. A one-entry product cache lets MUL-after-MULH pairs with identical operands complete without re-using the tree.

## Interface
- No parameters; widths are fixed constants in the shared package.
- clk  in  1  core clock; all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- flush_i  in  1  kill in-flight operation (EX flush)
- req_valid_i  in  1  request present
- req_ready_o  out  1  request accepted when valid&ready
- op_i  in  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
- a_i, b_i  in  32 each  operands rs1, rs2
- resp_valid_o  out  1  result available
- resp_ready_i  in  1  consumer takes result
- result_o  out  32  selected product half
- busy_o  out  1  state != IDLE
- tree_a_o, tree_b_o  out  33 each  sign/zero-extended operands to tree
- tree_sum_i, tree_carry_i  in  66 each  final compressor rows from tree

## Operation
- States: IDLE, TREE, ADD, DONE.
- IDLE: req_ready_o = !flush_i. On accept, latch op, a, b. Extension: a signed for MULH and MULHSU, b signed for MULH only; otherwise zero-extended to 33 bits.
- Cache hit on accept: cache_valid, a_i==ca, b_i==cb, and (op_i==MUL or op_i==cop). On a hit, result_o loads the cached half and the block goes directly to DONE. On a miss it goes to TREE.
- TREE: tree_a_o/tree_b_o driven from the latched registers. At the cycle's end, register tree_sum_i and tree_carry_i. Next state is ADD.
- ADD: p = (sum_q + carry_q) mod 2^66. result_o <= p[31:0] for MUL, else p[63:32]. The cache loads ca, cb, cop and p[63:0], and cache_valid is set. Next state is DONE.
- DONE: resp_valid_o = 1. result_o is held stable until resp_ready_i; then the block goes to IDLE. A new request cannot be accepted in the same cycle.
- flush_i in any state: the next state is IDLE and resp_valid_o is 0 next cycle. A flush in ADD suppresses the cache write. A flush in IDLE blocks acceptance. The flush does not clear an already-valid cache.
- tree_a_o/tree_b_o keep their last value outside TREE; they are not zeroed, to save toggles.

## Timing
- Reset values:
  - state: IDLE
  - resp_valid_o, busy_o: 0
  - result_o, tree_a_o, tree_b_o: 0
  - cache_valid: 0
  - req_ready_o = 1 once rst_n is high, if flush_i is low
- Miss latency: accept at edge 0; resp_valid_o high from cycle 3 (TREE at 1, ADD at 2, DONE at 3).
- Hit latency: resp_valid_o high in cycle 1.
- Throughput:
  - miss: one result per 4 cycles when resp_ready_i is tied high
  - hit: one result per 2 cycles
- Asserting rst_n low mid-operation forces all registers to their reset values immediately; no response is produced.
- No combinational path from req_valid_i or resp_ready_i to any output. req_ready_o depends on state and flush_i only.

## Structure
- Package mult_seq_pkg holds:
  - op encodings MUL/MULH/MULHSU/MULHU
  - state enum
  - widths: OPW=32, EXTW=33, PRODW=66
- Sub-module mult_final_add: 66-bit sum+carry adder plus half-select by op. It is combinational and instantiated once in the ADD path.
- The cache (ca, cb, cop, cprod, cache_valid) and the FSM stay in the top.

## Test plan
- MULHU a=0xFFFFFFFF, b=0xFFFFFFFF with an ideal tree model -> result 0xFFFFFFFE. resp_valid_o rises exactly 3 cycles after accept.
- MULH a=0x80000000, b=0x80000000 -> 0x40000000. A following MUL with the same operands hits the cache -> 0x00000000 in 1 cycle, with no TREE state entered.
- MULHSU a=0xFFFFFFFF (-1), b=0x00000002 -> 0xFFFFFFFF. A following MULH with the same operands misses (cop differs) and takes 3 cycles.
- Hold resp_ready_i low 5 cycles in DONE -> result_o and resp_valid_o stay stable; req_ready_o stays 0 throughout.
- Assert flush_i in ADD of MULH a=3, b=5 -> no response. Then MUL a=3, b=5 misses and yields 0x0000000F.
- Pulse rst_n low during TREE -> all outputs reset asynchronously. The next request starts cleanly, and a repeat of the pre-reset operands misses the cache.
